// File: rtl/step_trace_pkg.sv
// Shared codes for the step/trace controller: command modes, FSM states and
// readout field selectors.
package step_trace_pkg;

   typedef enum logic [1:0] {
      MODE_STEP_N = 2'd0,
      MODE_RUN    = 2'd1,
      MODE_HALT   = 2'd2,
      MODE_CLEAR  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_STEP    = 2'd1,
      S_CAPTURE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      FLD_INST = 2'd0,
      FLD_A    = 2'd1,
      FLD_B    = 2'd2,
      FLD_OP   = 2'd3
   } field_e;

endpackage

// File: rtl/step_trace_if.sv
// Command handshake between the board/bench and the step/trace controller.
interface step_trace_if
   import step_trace_pkg::*;
#(
   parameter int STEP_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   mode_e             cmd_mode;
   logic [STEP_W-1:0] cmd_count;

   modport master (output cmd_valid, cmd_mode, cmd_count, input cmd_ready);
   modport slave  (input cmd_valid, cmd_mode, cmd_count, output cmd_ready);
endinterface

// File: rtl/step_trace_ram.sv
// Trace record storage: one synchronous write port, one asynchronous read port.
module trace_ram #(
   parameter int DEPTH = 16,
   parameter int W     = 99
) (
   input  logic                     CLK,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [W-1:0]             rdata
);
   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/step_trace.sv
// Single-step / free-run controller for the CPU clock-enable, with a circular
// trace of the debug bus and a registered byte-wide readout.
module step_trace
   import step_trace_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OP_W   = 3,
   parameter int DEPTH  = 16,
   parameter int STEP_W = 8
) (
   input  logic                     CLK,
   input  logic                     RST,
   step_trace_if.slave              cmd,
   output logic                     cpu_ce,
   input  logic [DATA_W-1:0]        dbg_inst,
   input  logic [DATA_W-1:0]        dbg_a,
   input  logic [DATA_W-1:0]        dbg_b,
   input  logic [OP_W-1:0]          dbg_op,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   input  logic [1:0]               rd_field,
   input  logic [2:0]               SEL,
   output logic [7:0]               LED,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     cmd_err
);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int REC_W  = 3*DATA_W + OP_W;
   localparam int NBYTES = DATA_W/8;
   localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];

   state_e            state;
   logic [STEP_W-1:0] remaining;
   logic              free_run;
   logic              halt_q;
   logic [PTR_W-1:0]  wr_ptr;

   logic              accept, do_halt, stop, more;
   logic [PTR_W-1:0]  raddr;
   logic [REC_W-1:0]  rdata;
   logic [DATA_W-1:0] fld;
   logic [7:0]        byte_v;
   logic              rd_ok;

   // Commands are never back-pressured: busy-time commands are either a halt or dropped.
   assign cmd.cmd_ready = 1'b1;
   assign accept  = cmd.cmd_valid & cmd.cmd_ready;
   assign do_halt = accept && (cmd.cmd_mode == MODE_HALT);
   assign stop    = halt_q | do_halt;
   // remaining is decremented on this same edge, so >1 here means steps left afterwards
   assign more    = free_run | (remaining > STEP_W'(1));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= S_IDLE;
         remaining <= '0;
         free_run  <= 1'b0;
         halt_q    <= 1'b0;
         wr_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         cpu_ce    <= 1'b0;
         busy      <= 1'b0;
         cmd_err   <= 1'b0;
      end else begin
         cpu_ce  <= 1'b0;
         cmd_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  case (cmd.cmd_mode)
                     MODE_STEP_N: if (cmd.cmd_count != '0) begin
                        remaining <= cmd.cmd_count;
                        free_run  <= 1'b0;
                        halt_q    <= 1'b0;
                        state     <= S_STEP;
                        cpu_ce    <= 1'b1;
                        busy      <= 1'b1;
                     end
                     MODE_RUN: begin
                        free_run <= 1'b1;
                        halt_q   <= 1'b0;
                        state    <= S_STEP;
                        cpu_ce   <= 1'b1;
                        busy     <= 1'b1;
                     end
                     MODE_CLEAR: begin
                        wr_ptr   <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
            S_STEP: begin
               state <= S_CAPTURE;
               if (do_halt)     halt_q  <= 1'b1;
               else if (accept) cmd_err <= 1'b1;
            end
            S_CAPTURE: begin
               wr_ptr <= wr_ptr + PTR_W'(1);
               if (count == FULL) overflow <= 1'b1;
               else               count    <= count + (PTR_W+1)'(1);
               if (!free_run) remaining <= remaining - STEP_W'(1);
               if (accept && !do_halt) cmd_err <= 1'b1;
               if (stop || !more) begin
                  state  <= S_IDLE;
                  busy   <= 1'b0;
                  halt_q <= 1'b0;
               end else begin
                  state  <= S_STEP;
                  cpu_ce <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   trace_ram #(.DEPTH(DEPTH), .W(REC_W)) u_ram (
      .CLK   (CLK),
      .we    (state == S_CAPTURE),
      .waddr (wr_ptr),
      .wdata ({dbg_inst, dbg_a, dbg_b, dbg_op}),
      .raddr (raddr),
      .rdata (rdata)
   );

   // index 0 is the most recently written record
   assign raddr = wr_ptr - PTR_W'(1) - rd_idx;

   always_comb begin
      fld = '0;
      case (rd_field)
         FLD_INST: fld = rdata[REC_W-1 -: DATA_W];
         FLD_A:    fld = rdata[REC_W-DATA_W-1 -: DATA_W];
         FLD_B:    fld = rdata[OP_W +: DATA_W];
         default:  fld = DATA_W'(rdata[OP_W-1:0]);
      endcase
      byte_v = 8'(fld >> {SEL, 3'b000});
      rd_ok  = (int'(SEL) < NBYTES) && ({1'b0, rd_idx} < count);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) LED <= 8'h00;
      else      LED <= rd_ok ? byte_v : 8'h00;
   end
endmodule
